// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between two
// writeback requesters with round-robin arbitration and a pending-write
// scoreboard for read-after-write hazard detection at decode.
//
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   a_valid/a_rd/a_data        requester A (ALU / ADDI / JAL link)
//   a_ready                    A accepted this cycle (combinational)
//   b_valid/b_rd/b_data        requester B (load unit)
//   b_ready                    B accepted this cycle (combinational)
//   issue_valid/issue_rd       decode issues a writer of issue_rd
//   chk_rs1/chk_rs2            source registers to check
//   hazard1/hazard2            source has a write outstanding
//   RegWrite/rf_writereg/
//   rf_writedata               registered register file write port
//   conflict_cnt               saturating count of contested cycles

module regfile_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rf_writereg,
    output logic [DATA_W-1:0] rf_writedata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int NREG = 1 << ADDR_W;

    // last_b set means B won the most recent transfer, so A wins a contest.
    logic              last_b;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic              xfer;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

    always_comb begin
        a_ready = a_valid && (!b_valid || last_b);
        b_ready = b_valid && (!a_valid || !last_b);
    end

    assign xfer     = a_ready || b_ready;
    assign win_rd   = a_ready ? a_rd : b_rd;
    assign win_data = a_ready ? a_data : b_data;

    // Clear comes first so a same-cycle set of the same register wins:
    // the newer producer is still in flight.
    always_comb begin
        pending_nxt = pending;
        if (RegWrite) begin
            pending_nxt[rf_writereg] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // The register file only commits at the end of the RegWrite cycle,
    // so the pending bit is still set while RegWrite is high.
    assign hazard1 = pending[chk_rs1] && (chk_rs1 != '0);
    assign hazard2 = pending[chk_rs2] && (chk_rs2 != '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_b       <= 1'b1;
            pending      <= '0;
            RegWrite     <= 1'b0;
            rf_writereg  <= '0;
            rf_writedata <= '0;
            conflict_cnt <= '0;
        end else begin
            RegWrite <= xfer && (win_rd != '0);
            if (xfer) begin
                last_b       <= b_ready;
                rf_writereg  <= win_rd;
                rf_writedata <= win_data;
            end
            if (a_valid && b_valid && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
            pending <= pending_nxt;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x64 register file between two writeback requesters: A (ALU/ADDI/JAL link) and B (load unit).
- Round-robin arbitration with a valid/ready handshake. Write-port outputs are registered.
- Holds a pending-write scoreboard so decode can detect read-after-write hazards on rs1/rs2.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- DATA_W, 64, writeback data width
- ADDR_W, 5, register index width (32 registers)
- CNT_W, 16, width of the saturating contention counter

Ports:
- clk  in  1  clock, all state updates on the rising edge
- nrst  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a writeback
- a_rd  in  ADDR_W  destination register for A
- a_data  in  DATA_W  writeback data for A
- a_ready  out  1  A's writeback is accepted this cycle (combinational)
- b_valid  in  1  requester B has a writeback
- b_rd  in  ADDR_W  destination register for B
- b_data  in  DATA_W  writeback data for B
- b_ready  out  1  B's writeback is accepted this cycle (combinational)
- issue_valid  in  1  decode is issuing an instruction that will write issue_rd
- issue_rd  in  ADDR_W  destination register of the issuing instruction
- chk_rs1  in  ADDR_W  source register 1 to check for a hazard
- chk_rs2  in  ADDR_W  source register 2 to check for a hazard
- hazard1  out  1  chk_rs1 has a write outstanding (combinational)
- hazard2  out  1  chk_rs2 has a write outstanding (combinational)
- RegWrite  out  1  register file write enable (registered)
- rf_writereg  out  ADDR_W  register file write address (registered)
- rf_writedata  out  DATA_W  register file write data (registered)
- conflict_cnt  out  CNT_W  number of cycles in which both requesters were valid (saturating)

Behaviour:
- Reset is asynchronous on nrst low. While nrst is low:
  - RegWrite=0, rf_writereg=0, rf_writedata=0, conflict_cnt=0.
  - All pending bits are cleared.
  - The round-robin pointer is set so that A wins the next contest.
- Reset asserted mid-operation drops any in-flight writeback: no RegWrite pulse follows the reset.
- Grant logic is combinational:
  - If only A is valid, a_ready=1. If only B is valid, b_ready=1.
  - If both are valid, the requester other than the last winner is granted.
  - At most one ready is high in any cycle. A ready is never high while its valid is low.
- A transfer occurs when valid and ready are both high. Requesters must hold rd and data stable until their transfer.
- Round-robin pointer records the winner of every transfer, contested or not.
- Latency: a transfer at edge N produces RegWrite=1 with the transferred rd and data for the cycle after edge N. The register file commits the write at edge N+1.
- Writes to x0:
  - The transfer still completes (ready is granted).
  - RegWrite=0 in the following cycle. rf_writereg and rf_writedata still load the transferred rd and data.
  - No pending bit is touched.
- With no transfer, RegWrite=0 and rf_writereg/rf_writedata hold their previous values.
- Scoreboard, 32 pending bits:
  - Set: issue_valid=1 and issue_rd!=0 sets pending[issue_rd] at the edge.
  - Clear: RegWrite=1 clears pending[rf_writereg] at the same edge the register file commits.
  - Set and clear on the same register in the same cycle: set wins (a newer producer is in flight).
  - pending[0] is always 0.
- Hazard outputs:
  - hazard1 = pending[chk_rs1] and chk_rs1!=0. hazard2 is the same for chk_rs2.
  - hazard stays high through the RegWrite cycle, because the register file read still returns the old value until the commit edge.
- conflict_cnt increments on each edge where a_valid and b_valid are both 1. It saturates at all-ones and does not wrap.
- Back-to-back operation: a new transfer is allowed every cycle, so sustained throughput is one write per cycle.

Test Plan:
- Reset: hold nrst=0 with a_valid=1 -> RegWrite=0, conflict_cnt=0, hazard1=hazard2=0. Release reset -> A is granted on the first cycle.
- Single requester: a_valid=1, a_rd=5, a_data=64'h1234 for one cycle -> a_ready=1 that cycle. Next cycle RegWrite=1, rf_writereg=5, rf_writedata=64'h1234. The cycle after, RegWrite=0.
- Contention: both requesters valid for 4 cycles, a_rd=3, b_rd=4 -> grants go A, B, A, B. RegWrite pulses 4 consecutive cycles with rf_writereg 3,4,3,4. conflict_cnt=4.
- Scoreboard: issue_valid with issue_rd=7, then chk_rs1=7 -> hazard1=1. B writes rd=7 -> hazard1=1 through the RegWrite cycle, then 0. Separately, set and clear of rd=7 in the same cycle -> hazard1 stays 1.
- x0 handling: issue_rd=0 -> hazard1=0 when chk_rs1=0. a_rd=0 -> a_ready=1 and RegWrite stays 0.
- Saturation and reset mid-operation: with CNT_W=2, both requesters valid for 5 cycles -> conflict_cnt stops at 3. Assert nrst during a RegWrite=1 cycle -> RegWrite drops to 0 immediately and all pending bits clear.
